// File: rtl/bus_pkg.sv
// Shared types and decode helpers for the 8085-style machine-cycle sequencer.
package bus_pkg;

  typedef enum logic [2:0] {
    OPF  = 3'd0,
    MRD  = 3'd1,
    MWR  = 3'd2,
    IORD = 3'd3,
    IOWR = 3'd4
  } cyc_t;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StTw,
    StT3,
    StT4
  } tstate_t;

  // Returns {S1, S0, IOMn}.
  function automatic logic [2:0] status_enc(cyc_t t);
    case (t)
      OPF:     return 3'b110;
      MRD:     return 3'b100;
      MWR:     return 3'b010;
      IORD:    return 3'b101;
      IOWR:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_read(cyc_t t);
    return (t == OPF) || (t == MRD) || (t == IORD);
  endfunction

  function automatic logic is_write(cyc_t t);
    return (t == MWR) || (t == IOWR);
  endfunction

  function automatic logic is_valid(logic [2:0] raw);
    return raw <= 3'd4;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_wait_timer.sv
// Wait-state counter: cleared in T2, counts TW cycles, flags the last allowed wait.
module bus_cycle_ctrl_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the TW cycle whose ending edge would make the count reach MAX_WAIT.
  assign limit_o = (cnt_q == CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085-style T-state bus cycle sequencer. Define WAIT_TIMEOUT_EN to abort wait
// states after MAX_WAIT TW cycles.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        cyc_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout,
  input  logic              READY,
  output logic              ALE,
  output logic              S0,
  output logic              S1,
  output logic              IOMn,
  output logic              RDn,
  output logic              WRn,
  output logic [ADDR_W-1:0] ADD,
  output logic [DATA_W-1:0] DATA_O,
  output logic              DATA_OE,
  input  logic [DATA_W-1:0] DATA_I
);

  tstate_t           state_q, state_d;
  cyc_t              typ_q, typ_d;
  logic              ale_q, ale_d;
  logic [2:0]        stat_q, stat_d;
  logic              rdn_q, rdn_d;
  logic              wrn_q, wrn_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              tout_q, tout_d;
  logic              accept, abort, wait_limit, strobe;

`ifdef WAIT_TIMEOUT_EN
  bus_cycle_ctrl_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == StT2),
    .inc_i   (state_q == StTw),
    .limit_o (wait_limit)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign wait_limit      = 1'b0;
`endif

  assign accept = (state_q == StIdle) && req && is_valid(cyc_type);

  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StT1;
          typ_d   = cyc_t'(cyc_type);
        end
      end
      StT1: state_d = StT2;
      StT2: state_d = READY ? StT3 : StTw;
      StTw: begin
        if (READY) begin
          state_d = StT3;
        end else if (wait_limit) begin
          state_d = StIdle;
          abort   = 1'b1;
        end
      end
      StT3:    state_d = (typ_q == OPF) ? StT4 : StIdle;
      StT4:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus pins are registered from the next state so they change with the T-state edge.
  always_comb begin
    strobe  = (state_d == StT2) || (state_d == StTw) || (state_d == StT3);
    ale_d   = (state_d == StT1);
    stat_d  = (state_d != StIdle) ? status_enc(typ_d) : 3'b000;
    rdn_d   = !(strobe && is_read(typ_d));
    wrn_d   = !(strobe && is_write(typ_d));
    oe_d    = is_write(typ_d) && (strobe || (state_d == StT1));
    add_d   = accept ? addr : add_q;
    dout_d  = (accept && is_write(cyc_t'(cyc_type))) ? wdata : dout_q;
    rdata_d = ((state_q == StT3) && is_read(typ_q)) ? DATA_I : rdata_q;
    done_d  = (state_q != StIdle) && (state_d == StIdle);
    tout_d  = abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      typ_q   <= OPF;
      ale_q   <= 1'b0;
      stat_q  <= 3'b000;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      oe_q    <= 1'b0;
      add_q   <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      ale_q   <= ale_d;
      stat_q  <= stat_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      oe_q    <= oe_d;
      add_q   <= add_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  assign ack          = accept;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign timeout      = tout_q;
  assign rdata        = rdata_q;
  assign ALE          = ale_q;
  assign {S1, S0, IOMn} = stat_q;
  assign RDn          = rdn_q;
  assign WRn          = wrn_q;
  assign ADD          = add_q;
  assign DATA_O       = dout_q;
  assign DATA_OE      = oe_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl; timeout section follows WAIT_TIMEOUT_EN.
module tb_bus_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] cyc_type;
  logic [7:0] addr, wdata, rdata, ADD, DATA_O, DATA_I;
  logic       ack, busy, done, timeout, READY;
  logic       ALE, S0, S1, IOMn, RDn, WRn, DATA_OE;

  int n_cmp = 0;
  int n_err = 0;

  bus_cycle_ctrl #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .MAX_WAIT (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cyc_type (cyc_type),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .timeout  (timeout),
    .READY    (READY),
    .ALE      (ALE),
    .S0       (S0),
    .S1       (S1),
    .IOMn     (IOMn),
    .RDn      (RDn),
    .WRn      (WRn),
    .ADD      (ADD),
    .DATA_O   (DATA_O),
    .DATA_OE  (DATA_OE),
    .DATA_I   (DATA_I)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; cyc_type = 3'd0; addr = 8'h00; wdata = 8'h00;
    READY = 1'b1; DATA_I = 8'h00;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ale", ALE, 1'b0);
    chk("rst_s1s0", {S1, S0}, 2'b00);
    chk("rst_iom", IOMn, 1'b0);
    chk("rst_rd_wr", {RDn, WRn}, 2'b11);
    chk("rst_add", ADD, 8'h00);
    chk("rst_dout", {DATA_OE, DATA_O}, 9'h000);
    chk("rst_flags", {ack, busy, done, timeout}, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);

    // OPF from 0x10, READY high
    req = 1'b1; cyc_type = 3'd0; addr = 8'h10; DATA_I = 8'h3E;
    #1 chk("opf_ack", ack, 1'b1);
    tick(); req = 1'b0;
    chk("opf_t1_ale", ALE, 1'b1);
    chk("opf_t1_add", ADD, 8'h10);
    chk("opf_t1_stat", {S1, S0, IOMn}, 3'b110);
    chk("opf_t1_rd", {RDn, busy, ack}, 3'b110);
    tick();
    chk("opf_t2", {ALE, RDn, WRn}, 3'b001);
    tick();
    chk("opf_t3", {RDn, done}, 2'b00);
    tick();
    chk("opf_t4", {RDn, S1, S0, done, busy}, 5'b11101);
    tick();
    chk("opf_done", {done, busy, S1, S0}, 4'b1000);
    chk("opf_rdata", rdata, 8'h3E);
    tick();
    chk("opf_done_pulse", done, 1'b0);

    // MWR 0xA5 to 0x20; DATA_I differs to prove rdata is untouched
    req = 1'b1; cyc_type = 3'd2; addr = 8'h20; wdata = 8'hA5; DATA_I = 8'h55;
    tick(); req = 1'b0;
    chk("mwr_t1_stat", {S1, S0, IOMn, ALE}, 4'b0101);
    chk("mwr_t1_data", {DATA_OE, DATA_O}, 9'h1A5);
    chk("mwr_t1_wr", WRn, 1'b1);
    tick();
    chk("mwr_t2", {WRn, RDn, DATA_OE}, 3'b011);
    tick();
    chk("mwr_t3", {WRn, DATA_OE, DATA_O}, 10'h0A5 | 10'h100);
    tick();
    chk("mwr_done", {done, WRn, DATA_OE, busy}, 4'b1100);
    chk("mwr_rdata", rdata, 8'h3E);

    // IORD from 0x07 with three READY=0 samples
    req = 1'b1; cyc_type = 3'd3; addr = 8'h07; READY = 1'b0;
    tick(); req = 1'b0;
    chk("iord_t1_stat", {S1, S0, IOMn}, 3'b101);
    tick();
    chk("iord_t2", RDn, 1'b0);
    tick();
    chk("iord_tw1", {RDn, busy}, 2'b01);
    tick();
    chk("iord_tw2", {RDn, busy}, 2'b01);
    tick();
    chk("iord_tw3", {RDn, busy, done}, 3'b010);
    READY = 1'b1; DATA_I = 8'hC4;
    tick();
    chk("iord_t3", {RDn, done}, 2'b00);
    tick();
    chk("iord_done", {done, RDn, IOMn}, 3'b110);
    chk("iord_rdata", rdata, 8'hC4);

    // Back-to-back MRD then MWR with req held
    req = 1'b1; cyc_type = 3'd1; addr = 8'h30; DATA_I = 8'h77;
    #1 chk("b2b_ack1", ack, 1'b1);
    tick();
    cyc_type = 3'd2; addr = 8'h31; wdata = 8'h99;
    #1 chk("b2b_busy_noack", {ack, busy}, 2'b01);
    tick(); tick(); tick();
    chk("b2b_done_ack", {done, ack}, 2'b11);
    chk("b2b_rdata", rdata, 8'h77);
    tick(); req = 1'b0;
    chk("b2b_t1", {ALE, S1, S0, done}, 4'b1010);
    chk("b2b_t1_bus", {ADD, DATA_O}, 16'h3199);
    tick(); tick(); tick();
    chk("b2b_done2", {done, WRn}, 2'b11);

    // Reset during T2 of MWR
    req = 1'b1; cyc_type = 3'd2; addr = 8'h40; wdata = 8'h12;
    tick(); req = 1'b0;
    tick();
    chk("rst_mid_t2", WRn, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_bus", {WRn, DATA_OE, S1, S0, busy, done}, 6'b100000);
    tick();
    chk("rst_mid_nodone", {done, busy}, 2'b00);

    // Invalid type 6 is never acknowledged
    req = 1'b1; cyc_type = 3'd6; addr = 8'h66;
    #1 chk("inv_ack", ack, 1'b0);
    tick();
    chk("inv_idle", {busy, ALE, ack}, 3'b000);
    req = 1'b0;

    // MRD with READY stuck low
    req = 1'b1; cyc_type = 3'd1; addr = 8'h50; READY = 1'b0; DATA_I = 8'hEE;
    tick(); req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("stuck_tw3", {RDn, busy, done}, 3'b010);
    tick();
`ifdef WAIT_TIMEOUT_EN
    chk("to_abort", {done, timeout, RDn, busy}, 4'b1110);
    chk("to_rdata", rdata, 8'h00);
    tick();
    chk("to_pulse", {done, timeout}, 2'b00);
`else
    chk("nto_tw4", {RDn, busy, timeout, done}, 4'b0100);
    READY = 1'b1;
    tick(); tick();
    chk("nto_done", {done, timeout}, 2'b10);
    chk("nto_rdata", rdata, 8'hEE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
